// File: rtl/program_loader.sv
// program_loader: streams DEPTH program bytes into the CPU RAM over the
// manual MAR/RAM path while the CPU is halted, then pulses the CPU reset and
// releases the halt. A source stall longer than TIMEOUT aborts the session
// and leaves the CPU halted so a partial program never runs.
module program_loader #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned TIMEOUT      = 1_000_000,
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       cpu_halt,
  output logic       cpu_rst,
  output logic       manual_mode,
  output logic [3:0] mar_address,
  output logic       mar_load,
  output logic [7:0] ram_data,
  output logic       ram_write,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned AW = 4;
  // Timer also runs through LOAD_ADDR/WRITE, so leave headroom above TIMEOUT-1.
  localparam int unsigned TW = $clog2(TIMEOUT + 3);
  localparam int unsigned CW = $clog2(RESET_CYCLES + 1);

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_LOAD_ADDR = 3'd2,
    S_WRITE     = 3'd3,
    S_CPU_RESET = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic [CW-1:0]   r_rst_cnt, w_rst_cnt_nxt;
  logic            r_cpu_halt, w_cpu_halt_nxt;
  logic            r_manual, w_manual_nxt;
  logic            r_error, w_error_nxt;
  logic            r_done, w_done_nxt;
  logic            w_handshake;

  // Strobes are decoded from the state register, so at most one is ever high.
  assign byte_ready  = (r_state == S_WAIT_BYTE);
  assign mar_load    = (r_state == S_LOAD_ADDR);
  assign ram_write   = (r_state == S_WRITE);
  assign cpu_rst     = (r_state == S_CPU_RESET);
  assign busy        = (r_state != S_IDLE);
  assign w_handshake = byte_valid & byte_ready;

  assign mar_address = r_addr;
  assign ram_data    = r_data;
  assign cpu_halt    = r_cpu_halt;
  assign manual_mode = r_manual;
  assign error       = r_error;
  assign done        = r_done;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_timer    <= '0;
      r_data     <= '0;
      r_rst_cnt  <= '0;
      r_cpu_halt <= 1'b0;
      r_manual   <= 1'b0;
      r_error    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_timer    <= w_timer_nxt;
      r_data     <= w_data_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_cpu_halt <= w_cpu_halt_nxt;
      r_manual   <= w_manual_nxt;
      r_error    <= w_error_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-register logic for the load sequence.
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_timer_nxt    = r_timer;
    w_data_nxt     = r_data;
    w_rst_cnt_nxt  = r_rst_cnt;
    w_cpu_halt_nxt = r_cpu_halt;
    w_manual_nxt   = r_manual;
    w_error_nxt    = r_error;
    w_done_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_WAIT_BYTE;
          w_addr_nxt     = '0;
          w_timer_nxt    = '0;
          w_error_nxt    = 1'b0;
          w_cpu_halt_nxt = 1'b1;
          w_manual_nxt   = 1'b1;
        end
      end

      S_WAIT_BYTE: begin
        if (w_handshake) begin
          w_data_nxt  = byte_data;
          w_timer_nxt = '0;
          w_state_nxt = S_LOAD_ADDR;
        end else if (r_timer >= TMO_LAST) begin
          // Abort: drop the manual path but keep the CPU halted.
          w_state_nxt  = S_IDLE;
          w_error_nxt  = 1'b1;
          w_manual_nxt = 1'b0;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end

      S_LOAD_ADDR: begin
        // Timeout is measured from the last accepted byte.
        w_timer_nxt = r_timer + TW'(1);
        w_state_nxt = S_WRITE;
      end

      S_WRITE: begin
        w_timer_nxt = r_timer + TW'(1);
        if (r_addr == ADDR_LAST) begin
          w_state_nxt   = S_CPU_RESET;
          w_manual_nxt  = 1'b0;
          w_rst_cnt_nxt = '0;
        end else begin
          w_addr_nxt  = r_addr + AW'(1);
          w_state_nxt = S_WAIT_BYTE;
        end
      end

      S_CPU_RESET: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt    = S_IDLE;
          w_cpu_halt_nxt = 1'b0;
          w_done_nxt     = 1'b1;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
